// File: rtl/emern_load_ctrl.sv
// Load sequencer for the SPI register frontend: commits a finished SPI write as an
// en_load window at the start of vblank, never while a transaction is in flight.
`timescale 1ns/1ps
module emern_load_ctrl #(
    parameter int unsigned LOAD_CYCLES = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_in,
    input  logic       frame_start,
    output logic       en_load,
    output logic       pending_out,
    output logic       busy_out,
    output logic [7:0] load_count_out
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOAD
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   relaunch_q, relaunch_d;
    logic                   en_load_q, en_load_d;
    logic                   pending_q, pending_d;
    logic                   busy_q, busy_d;
    logic [7:0]             count_q, count_d;

    logic cs_s;
    logic cs_active;
    logic cs_rise;
    logic relaunch_nxt;

    assign cs_s      = sync_q[SYNC_STAGES-1];
    assign cs_active = ~cs_s;
    assign cs_rise   = cs_s & ~cs_prev_q;

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], cs_in};
        cs_prev_d    = cs_s;
        state_d      = state_q;
        cnt_d        = cnt_q;
        relaunch_d   = relaunch_q;
        count_d      = count_q;
        en_load_d    = 1'b0;
        busy_d       = 1'b0;
        pending_d    = 1'b0;
        relaunch_nxt = relaunch_q | cs_rise;
        case (state_q)
            IDLE: begin
                // frame_start is deliberately ignored here, even alongside cs_rise
                if (cs_rise) begin
                    state_d   = ARMED;
                    pending_d = 1'b1;
                end
            end
            ARMED: begin
                pending_d = 1'b1;
                if (frame_start && !cs_active) begin
                    state_d   = LOAD;
                    cnt_d     = 4'(LOAD_CYCLES - 1);
                    count_d   = count_q + 8'd1;
                    en_load_d = 1'b1;
                    busy_d    = 1'b1;
                    pending_d = 1'b0;
                end
            end
            LOAD: begin
                if (cnt_q == 4'd0) begin
                    // a write finishing on the exit cycle still relaunches
                    relaunch_d = 1'b0;
                    pending_d  = relaunch_nxt;
                    state_d    = relaunch_nxt ? ARMED : IDLE;
                end else begin
                    cnt_d      = cnt_q - 4'd1;
                    en_load_d  = 1'b1;
                    busy_d     = 1'b1;
                    relaunch_d = relaunch_nxt;
                    pending_d  = relaunch_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_q     <= '1;
            cs_prev_q  <= 1'b1;
            cnt_q      <= '0;
            relaunch_q <= 1'b0;
            en_load_q  <= 1'b0;
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            cs_prev_q  <= cs_prev_d;
            cnt_q      <= cnt_d;
            relaunch_q <= relaunch_d;
            en_load_q  <= en_load_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
        end
    end

    assign en_load        = en_load_q;
    assign pending_out    = pending_q;
    assign busy_out       = busy_q;
    assign load_count_out = count_q;

endmodule

// File: tb/tb_emern_load_ctrl.sv
// Directed bench for emern_load_ctrl: default instance plus LOAD_CYCLES=1 and
// SYNC_STAGES=3 instances driven from the same stimulus.
`timescale 1ns/1ps
module tb_emern_load_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cs_in;
    logic       frame_start;

    logic       en_load, pending_out, busy_out;
    logic [7:0] load_count_out;
    logic       en_load_l1, pending_l1, busy_l1;
    logic [7:0] count_l1;
    logic       en_load_s3, pending_s3, busy_s3;
    logic [7:0] count_s3;

    int n_tests = 0;
    int n_fail  = 0;

    emern_load_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cs_in(cs_in), .frame_start(frame_start),
        .en_load(en_load), .pending_out(pending_out), .busy_out(busy_out),
        .load_count_out(load_count_out)
    );

    emern_load_ctrl #(.LOAD_CYCLES(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .cs_in(cs_in), .frame_start(frame_start),
        .en_load(en_load_l1), .pending_out(pending_l1), .busy_out(busy_l1),
        .load_count_out(count_l1)
    );

    emern_load_ctrl #(.SYNC_STAGES(3)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .cs_in(cs_in), .frame_start(frame_start),
        .en_load(en_load_s3), .pending_out(pending_s3), .busy_out(busy_s3),
        .load_count_out(count_s3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic commit_write();
        cs_in = 1'b0;
        tick(5);
        cs_in = 1'b1;
        tick(4);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        cs_in       = 1'b0;
        frame_start = 1'b0;

        // reset held with cs low and frame_start toggling
        for (int i = 0; i < 4; i++) begin
            frame_start = (i % 2 == 0);
            tick(1);
            chk("rst_en_load", {7'd0, en_load}, 8'd0);
            chk("rst_pending", {7'd0, pending_out}, 8'd0);
            chk("rst_busy", {7'd0, busy_out}, 8'd0);
            chk("rst_count", load_count_out, 8'd0);
        end
        frame_start = 1'b0;
        cs_in       = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        chk("idle_pending", {7'd0, pending_out}, 8'd0);

        // basic commit
        cs_in = 1'b0;
        tick(40);
        cs_in = 1'b1;
        tick(2);
        chk("basic_pending_early", {7'd0, pending_out}, 8'd0);
        tick(1);
        chk("basic_pending_set", {7'd0, pending_out}, 8'd1);
        chk("s3_pending_early", {7'd0, pending_s3}, 8'd0);
        tick(1);
        chk("s3_pending_set", {7'd0, pending_s3}, 8'd1);
        tick(6);
        chk("basic_no_load_yet", {7'd0, en_load}, 8'd0);
        pulse_fs();
        chk("l1_en_load_on", {7'd0, en_load_l1}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            chk("basic_en_load_on", {7'd0, en_load}, 8'd1);
            chk("basic_busy_on", {7'd0, busy_out}, 8'd1);
            if (i == 0) begin
                chk("basic_pending_clr", {7'd0, pending_out}, 8'd0);
            end
            if (i == 1) begin
                chk("l1_en_load_off", {7'd0, en_load_l1}, 8'd0);
            end
            tick(1);
        end
        chk("basic_en_load_off", {7'd0, en_load}, 8'd0);
        chk("basic_busy_off", {7'd0, busy_out}, 8'd0);
        chk("basic_pending_off", {7'd0, pending_out}, 8'd0);
        chk("basic_count", load_count_out, 8'd1);

        // deferral: a new transaction overlaps frame_start
        commit_write();
        cs_in = 1'b0;
        tick(4);
        pulse_fs();
        chk("defer_no_load", {7'd0, en_load}, 8'd0);
        chk("defer_pending", {7'd0, pending_out}, 8'd1);
        tick(2);
        chk("defer_no_load2", {7'd0, en_load}, 8'd0);
        cs_in = 1'b1;
        tick(4);
        chk("defer_pending2", {7'd0, pending_out}, 8'd1);
        pulse_fs();
        for (int i = 0; i < 4; i++) begin
            chk("defer_en_load_on", {7'd0, en_load}, 8'd1);
            tick(1);
        end
        chk("defer_en_load_off", {7'd0, en_load}, 8'd0);
        chk("defer_count", load_count_out, 8'd2);

        // relaunch: cs_s rises during the 3rd cycle of LOAD
        commit_write();
        cs_in       = 1'b0;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        cs_in       = 1'b1;
        chk("rel_en_load_on", {7'd0, en_load}, 8'd1);
        tick(2);
        chk("rel_pending_before", {7'd0, pending_out}, 8'd0);
        tick(1);
        chk("rel_pending_flag", {7'd0, pending_out}, 8'd1);
        chk("rel_en_load_last", {7'd0, en_load}, 8'd1);
        tick(1);
        chk("rel_en_load_off", {7'd0, en_load}, 8'd0);
        chk("rel_pending_armed", {7'd0, pending_out}, 8'd1);
        chk("rel_count1", load_count_out, 8'd3);
        pulse_fs();
        for (int i = 0; i < 4; i++) begin
            chk("rel2_en_load_on", {7'd0, en_load}, 8'd1);
            tick(1);
        end
        chk("rel2_en_load_off", {7'd0, en_load}, 8'd0);
        chk("rel2_pending_off", {7'd0, pending_out}, 8'd0);
        chk("rel_count2", load_count_out, 8'd4);

        // cs_s rise coincides with frame_start in IDLE
        cs_in = 1'b0;
        tick(5);
        cs_in = 1'b1;
        tick(2);
        pulse_fs();
        chk("coin_no_load", {7'd0, en_load}, 8'd0);
        chk("coin_pending", {7'd0, pending_out}, 8'd1);
        tick(3);
        chk("coin_no_load2", {7'd0, en_load}, 8'd0);
        pulse_fs();
        chk("coin_load_next", {7'd0, en_load}, 8'd1);
        tick(4);
        chk("coin_load_off", {7'd0, en_load}, 8'd0);
        chk("coin_count", load_count_out, 8'd5);

        // frame_start with no transaction
        pulse_fs();
        chk("notx_no_load", {7'd0, en_load}, 8'd0);
        tick(2);
        chk("notx_no_load2", {7'd0, en_load}, 8'd0);
        chk("notx_pending", {7'd0, pending_out}, 8'd0);
        chk("notx_count", load_count_out, 8'd5);

        // async reset in the 2nd cycle of LOAD
        commit_write();
        pulse_fs();
        tick(1);
        chk("mid_en_load_on", {7'd0, en_load}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_en_load_drop", {7'd0, en_load}, 8'd0);
        chk("mid_busy_drop", {7'd0, busy_out}, 8'd0);
        chk("mid_count_clr", load_count_out, 8'd0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("mid_no_resume", {7'd0, en_load}, 8'd0);
        chk("mid_pending", {7'd0, pending_out}, 8'd0);

        // 257 commits wrap the 8-bit counter to 1
        for (int i = 0; i < 257; i++) begin
            commit_write();
            pulse_fs();
            tick(5);
        end
        chk("wrap_count", load_count_out, 8'd1);
        chk("wrap_idle", {7'd0, en_load}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/emern_load_ctrl.md
Name: emern_load_ctrl

Overview:
Load sequencer for the SPI register frontend (tt_um_emern_frontend). Watches the SPI chip select and the frame timing, and generates the frontend's en_load strobe. It commits a completed SPI register write only at the start of vertical blanking, and never while a transaction is in flight, so the rasterizer never sees half-updated colour/vertex/enable state mid-frame. Sits between the pad-level cs_in, the VGA timing generator and the frontend's en_load input.

Parameters:
LOAD_CYCLES, 4, width of the en_load pulse in clk cycles; legal range 1..15.
SYNC_STAGES, 2, number of flops in the cs_in synchronizer; legal range 2..3.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cs_in  input  1  SPI chip select from pad, active low, asynchronous to clk
frame_start  input  1  one-cycle pulse from VGA timing at the first vblank line
en_load  output  1  load strobe to frontend; shadow registers copy to outputs while high
pending_out  output  1  a completed write is waiting to be committed
busy_out  output  1  load window in progress
load_count_out  output  8  number of load windows started, wraps

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n=0: state=IDLE, en_load=0, pending_out=0, busy_out=0, load_count_out=0, all synchronizer flops=1 (cs idle), relaunch flag=0, down-counter=0.
- Reset asserted mid-LOAD drops en_load immediately, without waiting for a clock edge. No load resumes after release.
- cs_in passes through SYNC_STAGES flops to give cs_s.
  - cs_active = (cs_s==0).
  - cs_rise = cs_s is 1 and its previous registered value was 0. This marks the end of a transaction.
  - Both are evaluated only on synchronized values.
- FSM, all outputs registered:
  - IDLE: pending_out=0. On cs_rise go to ARMED. A frame_start in IDLE is ignored, even if it coincides with cs_rise. That write commits at the next frame_start.
  - ARMED: pending_out=1.
    - On frame_start with cs_active=0: go to LOAD, load down-counter with LOAD_CYCLES-1, increment load_count_out (255 wraps to 0).
    - On frame_start with cs_active=1: stay in ARMED. The commit is deferred to a later frame_start.
    - A cs_rise in ARMED is coalesced and has no further effect.
  - LOAD: en_load=1, busy_out=1.
    - en_load is high for exactly LOAD_CYCLES consecutive cycles, starting the cycle after frame_start is sampled.
    - The counter decrements each cycle. When it reaches 0, exit LOAD.
    - A cs_rise during LOAD sets the relaunch flag, and pending_out=1 while the flag is set.
    - frame_start during LOAD is ignored.
    - On exit: if relaunch=1, go to ARMED and clear the flag; otherwise go to IDLE.
- cs falling (new transaction start) during LOAD does not stop the window; the frontend shadow update is the frontend's concern.
- A cs_rise on the same cycle as the LOAD exit still sets the relaunch flag, and the FSM goes to ARMED.
- Latency: from frame_start high at edge N, en_load is high at edges N+1 .. N+LOAD_CYCLES.
- With LOAD_CYCLES=1, en_load is a single-cycle pulse and the FSM goes LOAD to IDLE/ARMED after one cycle.

Test Plan:
- Reset: hold rst_n=0 with cs_in=0 and frame_start pulsing. Required: en_load=0, pending_out=0, busy_out=0, load_count_out=0 throughout. Assert rst_n low at the 2nd cycle of a LOAD; en_load must fall within the same cycle.
- Basic commit: cs_in low 40 cycles then high, wait 10 cycles, pulse frame_start. Required: pending_out=1 from 2-3 cycles after cs rise. en_load high exactly 4 cycles starting 1 cycle after frame_start. Then pending_out=0 and load_count_out=1.
- Deferral: write completes, a second cs_in low overlaps the first frame_start. Required: no en_load and pending_out stays 1. Second cs rises, next frame_start gives one 4-cycle en_load. load_count_out increments by 1.
- Relaunch: cs rise occurs in the 3rd cycle of LOAD. Required: pending_out=1 after LOAD exits, FSM in ARMED, next frame_start gives a second window. load_count_out=2.
- Corner coincidences:
  - cs_s rise on the same cycle as frame_start in IDLE gives no load that frame, and a load on the following frame_start.
  - frame_start with no prior transaction gives no en_load.
- Counter wrap and parameters:
  - Run 257 commit cycles; load_count_out reads 1.
  - With LOAD_CYCLES=1, en_load is a 1-cycle pulse.
  - With SYNC_STAGES=3, pending_out rises 3-4 cycles after cs_in rise.
